// File: rtl/password_checker.sv
// Safe-box password checker: compares four scanner digits against a stored
// password and drives unlock, error and alarm outputs, with in-field reprogramming.
module password_checker #(
   parameter logic [15:0] DEFAULT_PW   = 16'h1234,
   parameter int          MAX_TRIES    = 3,
   parameter int          OPEN_CYCLES  = 250000000,
   parameter int          ERR_CYCLES   = 50000000,
   parameter int          ALARM_CYCLES = 500000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] p0,
   input  logic [4:0] p1,
   input  logic [4:0] p2,
   input  logic [4:0] p3,
   input  logic       enter_btn,
   input  logic       set_btn,
   input  logic       lock_btn,
   output logic       clr_entry,
   output logic       unlock,
   output logic       err_led,
   output logic       alarm,
   output logic [1:0] fail_cnt,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_OPEN    = 3'd2,
      S_SET_NEW = 3'd3,
      S_ERROR   = 3'd4,
      S_ALARM   = 3'd5
   } state_t;

   localparam logic [31:0] OPEN_LAST  = 32'(OPEN_CYCLES - 1);
   localparam logic [31:0] ERR_LAST   = 32'(ERR_CYCLES - 1);
   localparam logic [31:0] ALARM_LAST = 32'(ALARM_CYCLES - 1);
   localparam logic [2:0]  TRIES      = 3'(MAX_TRIES);

   state_t      state, state_nxt;
   logic [15:0] pw, pw_nxt;
   logic [1:0]  fail_nxt;
   logic [31:0] timer, timer_nxt;
   logic        clr_nxt;
   logic        enter_prev, set_prev, lock_prev;
   logic        ev_enter, ev_set, ev_lock;
   logic        full, match, open_to;
   logic [15:0] entered;

   assign ev_enter  = enter_btn & ~enter_prev;
   assign ev_set    = set_btn & ~set_prev;
   assign ev_lock   = lock_btn & ~lock_prev;
   assign full      = ~p0[4] & ~p1[4] & ~p2[4] & ~p3[4];
   assign entered   = {p0[3:0], p1[3:0], p2[3:0], p3[3:0]};
   assign match     = full & (entered == pw);
   assign open_to   = (timer == OPEN_LAST);
   assign state_dbg = state;

   // NOTE: every variable is given a default before the case so that no path
   // leaves one unassigned; a missed branch would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      pw_nxt    = pw;
      fail_nxt  = fail_cnt;
      clr_nxt   = 1'b0;
      unique case (state)
         S_IDLE:
            if (ev_enter && full) state_nxt = S_CHECK;
         S_CHECK: begin
            clr_nxt = 1'b1;
            if (match) begin
               state_nxt = S_OPEN;
               fail_nxt  = 2'd0;
            end else if ({1'b0, fail_cnt} + 3'd1 == TRIES) begin
               state_nxt = S_ALARM;
               fail_nxt  = TRIES[1:0];
            end else begin
               state_nxt = S_ERROR;
               fail_nxt  = fail_cnt + 2'd1;
            end
         end
         S_OPEN:
            if (ev_lock || open_to) begin
               state_nxt = S_IDLE;
               clr_nxt   = 1'b1;
            end else if (ev_set) begin
               state_nxt = S_SET_NEW;
               clr_nxt   = 1'b1;
            end
         S_SET_NEW:
            // Relock and timeout take precedence over a simultaneous commit.
            if (ev_lock || open_to) begin
               state_nxt = S_IDLE;
               clr_nxt   = 1'b1;
            end else if (ev_enter && full) begin
               state_nxt = S_OPEN;
               pw_nxt    = entered;
               clr_nxt   = 1'b1;
            end
         S_ERROR:
            if (timer == ERR_LAST) state_nxt = S_IDLE;
         S_ALARM:
            if (timer == ALARM_LAST) begin
               state_nxt = S_IDLE;
               fail_nxt  = 2'd0;
            end
         default:
            state_nxt = S_IDLE;
      endcase

      // Every commit is also a state change, so one comparison covers both clears.
      if (state_nxt != state)
         timer_nxt = 32'd0;
      else if (state inside {S_OPEN, S_SET_NEW, S_ERROR, S_ALARM})
         timer_nxt = timer + 32'd1;
      else
         timer_nxt = timer;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         // NOTE: the password is a plain 16-bit register, not a memory array,
         // so it can and must return to the default on reset.
         pw         <= DEFAULT_PW;
         fail_cnt   <= 2'd0;
         timer      <= 32'd0;
         enter_prev <= 1'b0;
         set_prev   <= 1'b0;
         lock_prev  <= 1'b0;
         clr_entry  <= 1'b0;
         unlock     <= 1'b0;
         err_led    <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         state      <= state_nxt;
         pw         <= pw_nxt;
         fail_cnt   <= fail_nxt;
         timer      <= timer_nxt;
         enter_prev <= enter_btn;
         set_prev   <= set_btn;
         lock_prev  <= lock_btn;
         clr_entry  <= clr_nxt;
         unlock     <= (state_nxt == S_OPEN) || (state_nxt == S_SET_NEW);
         err_led    <= (state_nxt == S_ERROR);
         alarm      <= (state_nxt == S_ALARM);
      end
   end

endmodule

// File: tb/tb_password_checker.sv
// Bench for password_checker: directed scenarios plus random stimulus, all
// checked every cycle against a countdown-based behavioural model.
module tb_password_checker;

   localparam int OPEN_C  = 10;
   localparam int ERR_C   = 4;
   localparam int ALARM_C = 8;
   localparam int TRIES   = 3;

   localparam int M_IDLE = 0, M_CHECK = 1, M_OPEN = 2, M_SET = 3, M_ERROR = 4, M_ALARM = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] p0, p1, p2, p3;
   logic       enter_btn, set_btn, lock_btn;
   logic       clr_entry, unlock, err_led, alarm;
   logic [1:0] fail_cnt;
   logic [2:0] state_dbg;

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode, stored digits, failure count, cycles left in a timed mode.
   int         m_mode;
   logic [3:0] m_pw [4];
   int         m_fails;
   int         m_left;
   logic       m_pe, m_ps, m_pl;
   logic       m_clr;

   password_checker #(
      .DEFAULT_PW  (16'h1234),
      .MAX_TRIES   (TRIES),
      .OPEN_CYCLES (OPEN_C),
      .ERR_CYCLES  (ERR_C),
      .ALARM_CYCLES(ALARM_C)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .p0       (p0),
      .p1       (p1),
      .p2       (p2),
      .p3       (p3),
      .enter_btn(enter_btn),
      .set_btn  (set_btn),
      .lock_btn (lock_btn),
      .clr_entry(clr_entry),
      .unlock   (unlock),
      .err_led  (err_led),
      .alarm    (alarm),
      .fail_cnt (fail_cnt),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic ev_e, ev_s, ev_l, full, match;
      if (!rst) begin
         m_mode = M_IDLE; m_fails = 0; m_left = 0; m_clr = 1'b0;
         m_pw[0] = 4'd1; m_pw[1] = 4'd2; m_pw[2] = 4'd3; m_pw[3] = 4'd4;
         m_pe = 1'b0; m_ps = 1'b0; m_pl = 1'b0;
      end else begin
         ev_e = enter_btn && !m_pe;
         ev_s = set_btn && !m_ps;
         ev_l = lock_btn && !m_pl;
         m_pe = enter_btn; m_ps = set_btn; m_pl = lock_btn;
         full  = (p0 < 16) && (p1 < 16) && (p2 < 16) && (p3 < 16);
         match = full && p0[3:0] == m_pw[0] && p1[3:0] == m_pw[1] &&
                 p2[3:0] == m_pw[2] && p3[3:0] == m_pw[3];
         m_clr = 1'b0;
         case (m_mode)
            M_IDLE: if (ev_e && full) m_mode = M_CHECK;
            M_CHECK: begin
               m_clr = 1'b1;
               if (match) begin
                  m_mode = M_OPEN; m_left = OPEN_C; m_fails = 0;
               end else begin
                  m_fails++;
                  if (m_fails == TRIES) begin m_mode = M_ALARM; m_left = ALARM_C; end
                  else begin m_mode = M_ERROR; m_left = ERR_C; end
               end
            end
            M_OPEN: begin
               m_left--;
               if (ev_l || m_left == 0) begin m_mode = M_IDLE; m_clr = 1'b1; end
               else if (ev_s) begin m_mode = M_SET; m_left = OPEN_C; m_clr = 1'b1; end
            end
            M_SET: begin
               m_left--;
               if (ev_l || m_left == 0) begin m_mode = M_IDLE; m_clr = 1'b1; end
               else if (ev_e && full) begin
                  m_pw[0] = p0[3:0]; m_pw[1] = p1[3:0]; m_pw[2] = p2[3:0]; m_pw[3] = p3[3:0];
                  m_mode = M_OPEN; m_left = OPEN_C; m_clr = 1'b1;
               end
            end
            M_ERROR: begin
               m_left--;
               if (m_left == 0) m_mode = M_IDLE;
            end
            default: begin
               m_left--;
               if (m_left == 0) begin m_mode = M_IDLE; m_fails = 0; end
            end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("state_dbg", 32'(state_dbg), 32'(m_mode));
      chk("unlock", 32'(unlock), 32'(m_mode == M_OPEN || m_mode == M_SET));
      chk("err_led", 32'(err_led), 32'(m_mode == M_ERROR));
      chk("alarm", 32'(alarm), 32'(m_mode == M_ALARM));
      chk("fail_cnt", 32'(fail_cnt), 32'(m_fails));
      chk("clr_entry", 32'(clr_entry), 32'(m_clr));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic digits(input int a, input int b, input int c, input int d);
      p0 = 5'(a); p1 = 5'(b); p2 = 5'(c); p3 = 5'(d);
   endtask

   task automatic pulse_enter();
      enter_btn = 1'b1; tick();
      enter_btn = 1'b0; tick();
   endtask

   task automatic pulse_set();
      set_btn = 1'b1; tick();
      set_btn = 1'b0;
   endtask

   task automatic pulse_lock();
      lock_btn = 1'b1; tick();
      lock_btn = 1'b0;
   endtask

   initial begin
      int check_seen;
      rst = 1'b0; enter_btn = 1'b0; set_btn = 1'b0; lock_btn = 1'b0;
      digits(16, 16, 16, 16);
      ticks(2);
      chk("reset_state", 32'(state_dbg), 32'd0);
      chk("reset_outputs", {27'd0, clr_entry, unlock, err_led, alarm, |fail_cnt}, 32'd0);
      rst = 1'b1;
      tick();

      // 1: correct code opens for exactly OPEN_C cycles
      digits(1, 2, 3, 4);
      enter_btn = 1'b1; tick();
      chk("s1_check", 32'(state_dbg), 32'd1);
      enter_btn = 1'b0; tick();
      chk("s1_unlock", 32'(unlock), 32'd1);
      chk("s1_clr", 32'(clr_entry), 32'd1);
      ticks(OPEN_C - 1);
      chk("s1_still_open", 32'(unlock), 32'd1);
      tick();
      chk("s1_relock", 32'(unlock), 32'd0);
      chk("s1_relock_clr", 32'(clr_entry), 32'd1);

      // 2: wrong code then right code
      digits(1, 2, 3, 5);
      pulse_enter();
      chk("s2_err", 32'(err_led), 32'd1);
      chk("s2_fail1", 32'(fail_cnt), 32'd1);
      ticks(ERR_C - 1);
      chk("s2_err_hold", 32'(err_led), 32'd1);
      tick();
      chk("s2_err_off", 32'(err_led), 32'd0);
      digits(1, 2, 3, 4);
      pulse_enter();
      chk("s2_unlock", 32'(unlock), 32'd1);
      chk("s2_fail0", 32'(fail_cnt), 32'd0);
      pulse_lock();
      tick();

      // 3: three failures raise the alarm; enter ignored meanwhile
      digits(5, 5, 5, 5);
      for (int k = 0; k < TRIES - 1; k++) begin
         pulse_enter();
         ticks(ERR_C);
      end
      pulse_enter();
      chk("s3_alarm", 32'(alarm), 32'd1);
      chk("s3_fail3", 32'(fail_cnt), 32'd3);
      digits(1, 2, 3, 4);
      pulse_enter();
      chk("s3_ignored", 32'(state_dbg), 32'd5);
      ticks(ALARM_C - 3);
      chk("s3_alarm_hold", 32'(alarm), 32'd1);
      tick();
      chk("s3_alarm_off", 32'(alarm), 32'd0);
      chk("s3_fail_clear", 32'(fail_cnt), 32'd0);
      chk("s3_idle", 32'(state_dbg), 32'd0);

      // 4: program a new password
      pulse_enter();
      pulse_set();
      chk("s4_set_new", 32'(state_dbg), 32'd3);
      chk("s4_set_clr", 32'(clr_entry), 32'd1);
      digits(9, 8, 7, 6);
      enter_btn = 1'b1; tick();
      chk("s4_commit", 32'(state_dbg), 32'd2);
      chk("s4_commit_clr", 32'(clr_entry), 32'd1);
      enter_btn = 1'b0; tick();
      pulse_lock();
      chk("s4_locked", 32'(state_dbg), 32'd0);
      digits(1, 2, 3, 4);
      pulse_enter();
      chk("s4_old_fails", 32'(state_dbg), 32'd4);
      ticks(ERR_C);
      digits(9, 8, 7, 6);
      pulse_enter();
      chk("s4_new_opens", 32'(unlock), 32'd1);
      pulse_lock();
      tick();

      // 5: partial entry ignored; held enter gives one attempt
      digits(9, 8, 16, 6);
      enter_btn = 1'b1; tick();
      chk("s5_partial_state", 32'(state_dbg), 32'd0);
      chk("s5_partial_clr", 32'(clr_entry), 32'd0);
      enter_btn = 1'b0; tick();
      digits(9, 8, 7, 6);
      enter_btn = 1'b1;
      check_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state_dbg == 3'd1) check_seen++;
      end
      enter_btn = 1'b0;
      chk("s5_single_check", 32'(check_seen), 32'd1);
      tick();

      // 6: reset during SET_NEW; lock beats enter
      pulse_enter();
      pulse_set();
      digits(1, 1, 1, 1);
      rst = 1'b0; tick();
      chk("s6_rst_state", 32'(state_dbg), 32'd0);
      chk("s6_rst_outputs", {27'd0, clr_entry, unlock, err_led, alarm, |fail_cnt}, 32'd0);
      rst = 1'b1;
      digits(1, 2, 3, 4);
      pulse_enter();
      chk("s6_default_pw", 32'(unlock), 32'd1);
      pulse_set();
      digits(5, 5, 5, 5);
      lock_btn = 1'b1; enter_btn = 1'b1; tick();
      chk("s6_lock_wins", 32'(state_dbg), 32'd0);
      lock_btn = 1'b0; enter_btn = 1'b0; tick();
      digits(1, 2, 3, 4);
      pulse_enter();
      chk("s6_pw_kept", 32'(unlock), 32'd1);
      pulse_lock();
      tick();

      // Random phase against the model
      for (int i = 0; i < 800; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 4) digits(m_pw[0], m_pw[1], m_pw[2], m_pw[3]);
         else if (r == 9) digits($urandom_range(0, 9), 16, $urandom_range(0, 9), $urandom_range(0, 9));
         else if (r < 7) digits($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         enter_btn = ($urandom_range(0, 3) == 0);
         set_btn   = ($urandom_range(0, 5) == 0);
         lock_btn  = ($urandom_range(0, 11) == 0);
         rst       = ($urandom_range(0, 149) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
